// File: rtl/clz_share_ctrl.sv
// clz_share_ctrl: one shared count-leading-zeros/ones unit for two requesters.
// Round-robin arbitration, two registered stages (S1 operand, S2 result),
// valid/ready handshakes, and a requester-0 flush.
module clz_share_ctrl #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_op,
  input  logic [31:0]      req0_data,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_op,
  input  logic [31:0]      req1_data,
  input  logic [TAG_W-1:0] req1_tag,
  input  logic             flush0,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_src,
  output logic [TAG_W-1:0] resp_tag,
  output logic [5:0]       resp_count,
  output logic             busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RAW_W  = 5;
  localparam int unsigned CNT_W  = 6;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_e;

  stage_e s1_state_q, s1_state_d;
  stage_e s2_state_q, s2_state_d;
  logic   prio_q, prio_d;

  logic              s1_src_q;
  logic              s1_op_q;
  logic [DATA_W-1:0] s1_data_q;
  logic [TAG_W-1:0]  s1_tag_q;

  logic              s2_src_q;
  logic [TAG_W-1:0]  s2_tag_q;
  logic [CNT_W-1:0]  s2_count_q;

  logic s1_full, s2_full;
  logic s1_flush, s2_flush;
  logic resp_valid_c, xfer_c;
  logic s2_free_c, s1_adv_c, accept_ok_c;
  logic v0_eff_c, grant0_c, grant1_c, accept_c;
  logic s2_load_c;

  logic [DATA_W-1:0] unit_in;
  logic [RAW_W-1:0]  unit_raw;
  logic              unit_found;
  logic [CNT_W-1:0]  unit_count;

  // Stage occupancy, arbitration and handshake decode
  always_comb begin
    s1_full      = (s1_state_q == FULL);
    s2_full      = (s2_state_q == FULL);
    s1_flush     = flush0 & s1_full & ~s1_src_q;
    s2_flush     = flush0 & s2_full & ~s2_src_q;
    resp_valid_c = s2_full & ~s2_flush;
    xfer_c       = resp_valid_c & resp_ready;
    // A flushed requester-0 entry frees its S2 slot for a requester-1 entry behind it
    s2_free_c    = ~s2_full | xfer_c | s2_flush;
    s1_adv_c     = s1_full & s2_free_c;
    accept_ok_c  = ~s1_full | s1_adv_c;
    v0_eff_c     = req0_valid & ~flush0;
    grant0_c     = v0_eff_c & (~req1_valid | ~prio_q);
    grant1_c     = req1_valid & (~v0_eff_c | prio_q);
    accept_c     = accept_ok_c & (grant0_c | grant1_c);
    s2_load_c    = s2_free_c & s1_full & ~s1_flush;
  end

  // Shared count unit; the raw encoder reports 31 for an all-zero input
  always_comb begin
    unit_in    = s1_data_q ^ {DATA_W{s1_op_q}};
    unit_raw   = RAW_W'(DATA_W - 1);
    unit_found = 1'b0;
    for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
      if (!unit_found && unit_in[i]) begin
        unit_raw   = RAW_W'(int'(DATA_W) - 1 - i);
        unit_found = 1'b1;
      end
    end
    unit_count = (unit_in == '0) ? CNT_W'(DATA_W) : CNT_W'(unit_raw);
  end

  // Stage state and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_state_q <= EMPTY;
      s2_state_q <= EMPTY;
      prio_q     <= 1'b0;
    end else begin
      s1_state_q <= s1_state_d;
      s2_state_q <= s2_state_d;
      prio_q     <= prio_d;
    end
  end

  // Next-state for both stages and the priority pointer
  always_comb begin
    s1_state_d = s1_state_q;
    s2_state_d = s2_state_q;
    prio_d     = prio_q;
    if (accept_c) begin
      s1_state_d = FULL;
    end else if (s1_adv_c || s1_flush) begin
      s1_state_d = EMPTY;
    end
    if (s2_free_c) begin
      s2_state_d = s2_load_c ? FULL : EMPTY;
    end
    // Only a contended grant rotates priority
    if (accept_c && v0_eff_c && req1_valid) begin
      prio_d = ~prio_q;
    end
  end

  // Port outputs derived from stage state
  always_comb begin
    req0_ready = accept_ok_c & grant0_c;
    req1_ready = accept_ok_c & grant1_c;
    resp_valid = resp_valid_c;
    busy       = s1_full | s2_full;
  end

  // S1 operand register, loaded on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_src_q  <= 1'b0;
      s1_op_q   <= 1'b0;
      s1_data_q <= '0;
      s1_tag_q  <= '0;
    end else if (accept_c) begin
      s1_src_q  <= grant1_c;
      s1_op_q   <= grant1_c ? req1_op   : req0_op;
      s1_data_q <= grant1_c ? req1_data : req0_data;
      s1_tag_q  <= grant1_c ? req1_tag  : req0_tag;
    end
  end

  // S2 result register, loaded when S1 moves forward
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_src_q   <= 1'b0;
      s2_tag_q   <= '0;
      s2_count_q <= '0;
    end else if (s2_load_c) begin
      s2_src_q   <= s1_src_q;
      s2_tag_q   <= s1_tag_q;
      s2_count_q <= unit_count;
    end
  end

  assign resp_src   = s2_src_q;
  assign resp_tag   = s2_tag_q;
  assign resp_count = s2_count_q;

endmodule
